// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns PC, MAR and IR, issues one-byte reads to program RAM
// and hands the captured opcode to the control unit over a valid/ready handshake.
module instr_fetch #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              fu_clk,
  input  logic              fu_rst,
  input  logic              fu_en,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic [DATA_W-1:0] ir_out,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [ADDR_W-1:0] pc_out,
  input  logic              br_we,
  input  logic [ADDR_W-1:0] br_addr
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

  logic [2:0]        state_r, state_s;
  logic [ADDR_W-1:0] pc_r, pc_s;
  logic [ADDR_W-1:0] mar_r, mar_s;
  logic [DATA_W-1:0] ir_r, ir_s;
  logic              ir_valid_r, ir_valid_s;
  logic              mem_rd_r;

  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    pc_inc = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
  endfunction

  // Next-state and datapath update; br_we outranks every other event in a cycle.
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    mar_s      = mar_r;
    ir_s       = ir_r;
    ir_valid_s = ir_valid_r;
    case (state_r)
      ST_IDLE: begin
        if (br_we) begin
          pc_s       = br_addr;
          mar_s      = br_addr;
          ir_valid_s = 1'b0;
          state_s    = fu_en ? ST_ADDR : ST_IDLE;
        end else if (fu_en) begin
          mar_s   = pc_r;
          state_s = ST_ADDR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      // The read issued this cycle still goes out, so a jump here must drain it.
      ST_ADDR: begin
        if (br_we) begin
          pc_s       = br_addr;
          ir_valid_s = 1'b0;
          state_s    = ST_DRAIN;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (br_we) begin
          pc_s       = br_addr;
          ir_valid_s = 1'b0;
          if (mem_rvalid) begin
            mar_s   = br_addr;
            state_s = fu_en ? ST_ADDR : ST_IDLE;
          end else begin
            state_s = ST_DRAIN;
          end
        end else if (mem_rvalid) begin
          ir_s       = mem_rdata;
          pc_s       = pc_inc(pc_r);
          ir_valid_s = 1'b1;
          state_s    = ST_HOLD;
        end else begin
          state_s = ST_WAIT;
        end
      end
      // A jump coinciding with the drained response finishes the drain toward the new target.
      ST_DRAIN: begin
        if (br_we) begin
          pc_s       = br_addr;
          ir_valid_s = 1'b0;
          if (mem_rvalid) begin
            mar_s   = br_addr;
            state_s = fu_en ? ST_ADDR : ST_IDLE;
          end else begin
            state_s = ST_DRAIN;
          end
        end else if (mem_rvalid) begin
          mar_s   = pc_r;
          state_s = fu_en ? ST_ADDR : ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_HOLD: begin
        if (br_we) begin
          pc_s       = br_addr;
          mar_s      = br_addr;
          ir_valid_s = 1'b0;
          state_s    = fu_en ? ST_ADDR : ST_IDLE;
        end else if (ir_ready) begin
          ir_valid_s = 1'b0;
          if (fu_en) begin
            mar_s   = pc_r;
            state_s = ST_ADDR;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        ir_valid_s = 1'b0;
        state_s    = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; mem_rd is registered from the next state.
  always_ff @(posedge fu_clk or posedge fu_rst) begin
    if (fu_rst) begin
      state_r    <= ST_IDLE;
      pc_r       <= RESET_PC;
      mar_r      <= RESET_PC;
      ir_r       <= {DATA_W{1'b0}};
      ir_valid_r <= 1'b0;
      mem_rd_r   <= 1'b0;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      mar_r      <= mar_s;
      ir_r       <= ir_s;
      ir_valid_r <= ir_valid_s;
      mem_rd_r   <= (state_s == ST_ADDR);
    end
  end

  assign mem_rd   = mem_rd_r;
  assign mem_addr = mar_r;
  assign ir_out   = ir_r;
  assign ir_valid = ir_valid_r;
  assign pc_out   = pc_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected read addresses and IR/PC values are queued
// as stimulus is set up and compared as mem_rd pulses and handshakes occur.
module tb_instr_fetch;

  logic       fu_clk;
  logic       fu_rst;
  logic       fu_en;
  logic       mem_rd;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       mem_rvalid;
  logic [7:0] ir_out;
  logic       ir_valid;
  logic       ir_ready;
  logic [7:0] pc_out;
  logic       br_we;
  logic [7:0] br_addr;

  instr_fetch #(.ADDR_W(8), .DATA_W(8), .RESET_PC(8'h00)) dut (
    .fu_clk    (fu_clk),
    .fu_rst    (fu_rst),
    .fu_en     (fu_en),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_rvalid(mem_rvalid),
    .ir_out    (ir_out),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .pc_out    (pc_out),
    .br_we     (br_we),
    .br_addr   (br_addr)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         lat     = 1;
  int         cnt     = 0;
  logic [7:0] pend_addr;
  logic [7:0] mem [256];
  logic [7:0] exp_addr_q [$];
  logic [7:0] exp_ir_q [$];
  logic [7:0] exp_pc_q [$];
  int         rd_cyc_q [$];

  initial begin
    fu_clk = 1'b0;
    forever #5 fu_clk = ~fu_clk;
  end

  always @(posedge fu_clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge fu_clk);
    #1;
  endtask

  // RAM model: answers each mem_rd after lat cycles, even across a reset
  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = 8'h00;
    pend_addr  = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 16);
    forever begin
      tick();
      mem_rvalid = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem[pend_addr];
        end
      end
      if (mem_rd) begin
        cnt       = lat;
        pend_addr = mem_addr;
      end
    end
  end

  // Scoreboard: read addresses on mem_rd, IR and PC on each real handshake
  initial begin
    forever begin
      @(negedge fu_clk);
      if (mem_rd) begin
        rd_cyc_q.push_back(cyc);
        chk_eq("rd_expected", 32'(exp_addr_q.size() != 0), 32'd1);
        if (exp_addr_q.size() != 0) chk_eq("mem_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
      end
      if (ir_valid && ir_ready && !br_we && !fu_rst) begin
        chk_eq("hs_expected", 32'(exp_ir_q.size() != 0), 32'd1);
        if (exp_ir_q.size() != 0) begin
          chk_eq("ir_out", 32'(ir_out), 32'(exp_ir_q.pop_front()));
          chk_eq("pc_out_hs", 32'(pc_out), 32'(exp_pc_q.pop_front()));
        end
      end
    end
  end

  task automatic expect_fetch(input logic [7:0] addr, input bit consumed);
    logic [7:0] nxt;
    nxt = addr + 8'd1;
    exp_addr_q.push_back(addr);
    if (consumed) begin
      exp_ir_q.push_back(mem[addr]);
      exp_pc_q.push_back(nxt);
    end
  endtask

  task automatic run_out(input string tag);
    int n;
    n = 0;
    while (exp_addr_q.size() != 0 && n < 200) begin tick(); n++; end
    fu_en = 1'b0;
    while (exp_ir_q.size() != 0 && n < 200) begin tick(); n++; end
    chk_eq({tag, "_done"}, 32'(n < 200), 32'd1);
    repeat (4) tick();
  endtask

  task automatic wait_rd(input string tag);
    int n;
    n = 0;
    while (!mem_rd && n < 50) begin tick(); n++; end
    chk_eq({tag, "_rd_seen"}, 32'(mem_rd), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!ir_valid && n < 50) begin tick(); n++; end
    chk_eq({tag, "_valid_seen"}, 32'(ir_valid), 32'd1);
  endtask

  initial begin
    int c_hs;
    fu_rst   = 1'b1;
    fu_en    = 1'b0;
    ir_ready = 1'b1;
    br_we    = 1'b0;
    br_addr  = 8'h00;
    repeat (3) tick();
    chk_eq("rst_ir_valid", 32'(ir_valid), 32'd0);
    chk_eq("rst_pc", 32'(pc_out), 32'h00);
    chk_eq("rst_mem_rd", 32'(mem_rd), 32'd0);
    fu_rst = 1'b0;
    tick();
    chk_eq("rst_ir_out", 32'(ir_out), 32'h00);
    chk_eq("rst_mem_addr", 32'(mem_addr), 32'h00);

    // Zero-wait sequential fetch, one instruction per 3 cycles
    rd_cyc_q.delete();
    for (int a = 0; a < 3; a++) expect_fetch(8'(a), 1'b1);
    fu_en = 1'b1;
    run_out("seq");
    chk_eq("seq_rd_count", 32'(rd_cyc_q.size()), 32'd3);
    if (rd_cyc_q.size() >= 3) begin
      chk_eq("seq_gap0", 32'(rd_cyc_q[1] - rd_cyc_q[0]), 32'd3);
      chk_eq("seq_gap1", 32'(rd_cyc_q[2] - rd_cyc_q[1]), 32'd3);
    end

    // Control unit stalls 5 cycles in HOLD
    rd_cyc_q.delete();
    ir_ready = 1'b0;
    expect_fetch(8'h03, 1'b1);
    expect_fetch(8'h04, 1'b1);
    fu_en = 1'b1;
    wait_valid("stall");
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_eq("stall_valid", 32'(ir_valid), 32'd1);
      chk_eq("stall_ir", 32'(ir_out), 32'h13);
      chk_eq("stall_no_rd", 32'(mem_rd), 32'd0);
    end
    ir_ready = 1'b1;
    c_hs = cyc;
    run_out("stall");
    chk_eq("stall_rd_count", 32'(rd_cyc_q.size()), 32'd2);
    if (rd_cyc_q.size() >= 2) chk_eq("stall_next_rd", 32'(rd_cyc_q[1] - c_hs), 32'd1);

    // Jump to 0xFF from IDLE, then PC wraps to 0x00
    expect_fetch(8'hFF, 1'b1);
    expect_fetch(8'h00, 1'b1);
    br_we   = 1'b1;
    br_addr = 8'hFF;
    fu_en   = 1'b1;
    tick();
    br_we = 1'b0;
    run_out("wrap");
    chk_eq("wrap_pc", 32'(pc_out), 32'h01);

    // Jump while in WAIT with a 3-cycle RAM: stale byte is drained
    lat = 3;
    expect_fetch(8'h01, 1'b0);
    expect_fetch(8'h40, 1'b1);
    fu_en = 1'b1;
    wait_rd("br_wait");
    tick();
    br_we   = 1'b1;
    br_addr = 8'h40;
    tick();
    br_we = 1'b0;
    chk_eq("br_wait_valid", 32'(ir_valid), 32'd0);
    chk_eq("br_wait_pc", 32'(pc_out), 32'h40);
    run_out("br_wait");
    chk_eq("br_wait_pc_after", 32'(pc_out), 32'h41);
    lat = 1;

    // Jump in HOLD with ir_ready=1: handshake is squashed
    ir_ready = 1'b0;
    expect_fetch(8'h41, 1'b0);
    fu_en = 1'b1;
    wait_valid("br_hold");
    chk_eq("br_hold_ir", 32'(ir_out), 32'h51);
    expect_fetch(8'h80, 1'b1);
    ir_ready = 1'b1;
    br_we    = 1'b1;
    br_addr  = 8'h80;
    tick();
    br_we = 1'b0;
    chk_eq("br_hold_squash", 32'(ir_valid), 32'd0);
    chk_eq("br_hold_pc", 32'(pc_out), 32'h80);
    run_out("br_hold");

    // Reset mid-WAIT; the late response must be ignored in IDLE
    lat = 3;
    expect_fetch(8'h81, 1'b0);
    fu_en = 1'b1;
    wait_rd("rst_wait");
    tick();
    fu_rst = 1'b1;
    fu_en  = 1'b0;
    tick();
    fu_rst = 1'b0;
    chk_eq("rst2_pc", 32'(pc_out), 32'h00);
    chk_eq("rst2_mem_addr", 32'(mem_addr), 32'h00);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk_eq("rst2_valid", 32'(ir_valid), 32'd0);
      chk_eq("rst2_no_rd", 32'(mem_rd), 32'd0);
      chk_eq("rst2_pc_hold", 32'(pc_out), 32'h00);
      chk_eq("rst2_ir", 32'(ir_out), 32'h00);
    end

    chk_eq("addr_q_empty", 32'(exp_addr_q.size()), 32'd0);
    chk_eq("ir_q_empty", 32'(exp_ir_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
